bitlet_weight_scheduler_16: RTL
===============================

// Module: bitlet_weight_scheduler_16
// PURPOSE
//  Bitlet weight-side scheduler: the encoder that drives the MUX select/valid inputs of the Bitlet MAC.
//  Accepts one block of VEC_LENGTH signed weights, transposes it into DATA_WIDTH bit-columns, then emits one beat per cycle.
//  In each beat, every column picks the lowest-indexed weight still holding a 1 in that bit (sel) plus a valid flag.
//  Sits between the weight buffer and a row of Bitlet MACs; last/first flags drive MAC en/load_accum sequencing.
// PARAMETERS
//  DATA_WIDTH     8                    weight width = number of bit-columns
//  VEC_LENGTH     16                   weights per block = activation MUX fan-in
//  MUX_SEL_WIDTH  $clog2(VEC_LENGTH)   select width
// PORTS
//  clk        in   1                        clock
//  reset      in   1                        synchronous, active-high reset
//  w_valid    in   1                        weight block offered
//  w_ready    out  1                        scheduler can accept a block (IDLE only)
//  w_in       in   DATA_WIDTH x VEC_LENGTH  signed weights, w_in[i] = weight i
//  out_valid  out  1                        beat present on act_sel/act_val
//  out_ready  in   1                        consumer takes the beat
//  act_sel    out  MUX_SEL_WIDTH x DATA_WIDTH  per-column activation index
//  act_val    out  DATA_WIDTH                  per-column valid
//  out_first  out  1                        first beat of block (-> MAC load_accum)
//  out_last   out  1                        final beat of block
// BEHAVIOUR
//  Clock is clk; reset is synchronous and active-high on reset.
//  Reset: state=IDLE, mask=0; w_ready=1, out_valid=0, out_first=0, out_last=0, act_val=0, act_sel=0.
//  State: mask[j][i] (DATA_WIDTH x VEC_LENGTH); mask[j][i] = w_in[i][j] at load. Column 7 is the raw sign bit; negation is the MAC's job.
//  IDLE: w_ready=1, out_valid=0. On w_valid&&w_ready: latch mask, set first_pend=1, go to RUN.
//   out_valid rises the next cycle (load->first beat latency 1).
//  RUN: w_ready=0, out_valid=1.
//   act_val[j] = |mask[j].
//   act_sel[j] = index of the lowest set bit of mask[j]; 0 when act_val[j]=0.
//   out_first = first_pend.
//   out_last = 1 when every column has popcount<=1, i.e. the beat after this one would be empty.
//  Handshake: outputs are combinational from registered state and stay stable while out_ready=0.
//   On out_valid&&out_ready: clear the selected bit in every valid column, clear first_pend.
//   If out_last is also set, go to IDLE.
//  Beat count per block = max column popcount, minimum 1.
//   An all-zero block emits exactly one beat: act_val=0, out_first=out_last=1.
//  Next block: accepted the cycle after the last beat is taken, giving 1 bubble between blocks. There is no prefetch.
//  w_valid in RUN is ignored; w_in need not be held after acceptance.
//  Reset in RUN: the block is discarded and reset values are restored on the next edge. No partial beat is emitted.
// CONFIGURATION
//  BITLET_SCHED_STATS_EN defined: adds two 32-bit output ports, both cleared by reset and wrapping at 2^32.
//   stat_beats  counts accepted output beats.
//   stat_blocks counts accepted weight blocks.
//  BITLET_SCHED_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package bitlet_pkg holds DATA_WIDTH/VEC_LENGTH defaults, the sel_t select typedef and the state enum {IDLE, RUN}.
//  Sub-module prio_enc_lsb (VEC_LENGTH -> MUX_SEL_WIDTH + any-valid) is instantiated once per column.
//   It also outputs the one-hot lowest bit used for clearing.
//  Top level holds the FSM, mask register, first_pend, last detection (popcount<=1 via m & (m-1) == 0) and the optional counters.
// TESTING
//  All weights 0, out_ready=1: exactly 1 beat, act_val=8'h00, out_first=out_last=1; back to IDLE, w_ready=1 the next cycle.
//  Only w_in[3]=8'h81: 1 beat, act_val=8'h81, act_sel[0]=act_sel[7]=3, first=last=1.
//  All w_in[i]=8'hFF: 16 beats; beat k has act_sel[j]=k and act_val=8'hFF for every j; out_last only on beat 15.
//  w_in[2]=8'h01, w_in[9]=8'h01, w_in[5]=8'h02: 2 beats.
//   Beat 0: sel[0]=2, sel[1]=5, val=8'h03.
//   Beat 1: sel[0]=9, val=8'h01, last=1.
//  Same as the previous case with out_ready low for 3 cycles on beat 0: outputs are held unchanged, the mask is not cleared, and the total is still 2 beats.
//  reset asserted mid-RUN of the all-FF block: the next cycle shows out_valid=0, w_ready=1; a new block then schedules correctly.
//   With BITLET_SCHED_STATS_EN, stat_beats and stat_blocks read 0 after the reset.

Source files
------------

// File: rtl/bitlet_weight_scheduler_16_pkg.sv
// Shared parameters, select type and FSM state enum for the Bitlet weight scheduler.
package bitlet_pkg;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned VEC_LENGTH    = 16;
  localparam int unsigned MUX_SEL_WIDTH = $clog2(VEC_LENGTH);

  typedef logic [MUX_SEL_WIDTH-1:0]            sel_t;
  typedef sel_t [DATA_WIDTH-1:0]               sel_vec_t;
  typedef logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] wblk_t;   // wblk[i] = weight i
  typedef logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0] mask_t;   // mask[j][i] = bit j of weight i

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/bitlet_weight_scheduler_16_if.sv
// Weight-in / beat-out bundle between the weight buffer, the scheduler and the MAC row.
interface bitlet_weight_scheduler_16_if;
  import bitlet_pkg::*;

  logic     w_valid;
  logic     w_ready;
  wblk_t    w_in;
  logic     out_valid;
  logic     out_ready;
  sel_vec_t act_sel;
  logic [DATA_WIDTH-1:0] act_val;
  logic     out_first;
  logic     out_last;

  // Scheduler side: accepts weight blocks, produces beats
  modport slave (
    input  w_valid, w_in, out_ready,
    output w_ready, out_valid, act_sel, act_val, out_first, out_last
  );

  // Environment side: offers weight blocks, consumes beats
  modport master (
    output w_valid, w_in, out_ready,
    input  w_ready, out_valid, act_sel, act_val, out_first, out_last
  );

endinterface

// File: rtl/bitlet_weight_scheduler_16_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: index, any-valid flag and one-hot of the winning bit.
module prio_enc_lsb
  import bitlet_pkg::*;
(
  input  logic [VEC_LENGTH-1:0] i_vec,
  output sel_t                  o_idx,
  output logic                  o_any,
  output logic [VEC_LENGTH-1:0] o_onehot
);

  // Isolate lowest set bit (two's-complement trick)
  assign o_onehot = i_vec & (~i_vec + VEC_LENGTH'(1));
  assign o_any    = |i_vec;

  // Scan high to low so the lowest set index wins; 0 when empty
  always_comb begin
    o_idx = '0;
    for (int i = VEC_LENGTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = sel_t'(i);
    end
  end

endmodule

// File: rtl/bitlet_weight_scheduler_16.sv
// Bitlet weight-side scheduler: transposes a weight block into bit-columns and
// emits one beat per cycle selecting the lowest remaining weight per column.
// Optional feature macro: BITLET_SCHED_STATS_EN adds stat_beats/stat_blocks counters.
module bitlet_weight_scheduler_16
  import bitlet_pkg::*;
(
  input  logic clk,
  input  logic reset,
  bitlet_weight_scheduler_16_if.slave bus
`ifdef BITLET_SCHED_STATS_EN
  ,
  output logic [31:0] stat_beats,
  output logic [31:0] stat_blocks
`endif
);

  state_e r_state;
  mask_t  r_mask;
  logic   r_first_pend;

  mask_t                 w_load;
  mask_t                 w_cleared;
  mask_t                 w_onehot;
  sel_vec_t              w_sel;
  logic [DATA_WIDTH-1:0] w_any;
  logic [DATA_WIDTH-1:0] w_col_le1;
  logic                  w_last;
  logic                  w_run;
  logic                  w_fire_in;
  logic                  w_fire_out;

  // Transpose incoming weights into bit-columns
  always_comb begin
    w_load = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      for (int i = 0; i < VEC_LENGTH; i++) begin
        w_load[j][i] = bus.w_in[i][j];
      end
    end
  end

  // One encoder per column
  for (genvar j = 0; j < DATA_WIDTH; j++) begin : g_col
    prio_enc_lsb u_enc (
      .i_vec    (r_mask[j]),
      .o_idx    (w_sel[j]),
      .o_any    (w_any[j]),
      .o_onehot (w_onehot[j])
    );
    assign w_cleared[j] = r_mask[j] & ~w_onehot[j];
    assign w_col_le1[j] = (r_mask[j] & (r_mask[j] - VEC_LENGTH'(1))) == '0;
  end

  assign w_run      = (r_state == RUN);
  assign w_last     = &w_col_le1;
  assign w_fire_in  = bus.w_valid && (r_state == IDLE);
  assign w_fire_out = w_run && bus.out_ready;

  assign bus.w_ready   = (r_state == IDLE);
  assign bus.out_valid = w_run;
  assign bus.act_val   = w_run ? w_any : '0;
  assign bus.act_sel   = w_run ? w_sel : '0;
  assign bus.out_first = w_run && r_first_pend;
  assign bus.out_last  = w_run && w_last;

  // FSM, mask and first-beat flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_mask       <= '0;
      r_first_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire_in) begin
            r_mask       <= w_load;
            r_first_pend <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (w_fire_out) begin
            r_mask       <= w_cleared;
            r_first_pend <= 1'b0;
            if (w_last) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BITLET_SCHED_STATS_EN
  logic [31:0] r_stat_beats;
  logic [31:0] r_stat_blocks;

  // Free-running wrap-around counters of accepted beats and blocks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_beats  <= '0;
      r_stat_blocks <= '0;
    end else begin
      if (w_fire_out) r_stat_beats  <= r_stat_beats + 32'd1;
      if (w_fire_in)  r_stat_blocks <= r_stat_blocks + 32'd1;
    end
  end

  assign stat_beats  = r_stat_beats;
  assign stat_blocks = r_stat_blocks;
`endif

endmodule
